// File: rtl/regfile_pkg.sv
// Shared constants and types for the core register file.
//   DEF_DATA_W / DEF_ADDR_W : default register width and index width
//   NREGS                   : register count for the default index width
//   reg_addr_t / reg_data_t : register index and register value at default widths
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned NREGS      = 2 ** DEF_ADDR_W;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard: reserve at issue, release at writeback.
//   clk, startin       : clock, synchronous active-high reset
//   rd_addr / rd_busy  : per read port source register and its stall flag
//   wr_en / wr_addr    : writeback, releases the written register
//   rsv_en / rsv_addr  : reservation request; rsv_ok accepts it (combinational)
//   busy_cnt           : number of registers currently reserved
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     startin,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_ok,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int unsigned NREGS_L = 2 ** ADDR_W;
  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam bit          ZR      = (ZERO_REG != 0);

  logic [NREGS_L-1:0] busy;
  logic [NREGS_L-1:0] busy_next;
  logic [CNT_W-1:0]   cnt_next;
  logic               rsv_zero;
  logic               wr_zero;
  logic               rsv_set;
  logic               rel_hit;

  // Reservation acceptance and next busy state; reserve is applied after release
  // so a same-address release+reserve leaves the register busy.
  always_comb begin
    rsv_zero  = ZR && (rsv_addr == '0);
    wr_zero   = ZR && (wr_addr == '0);
    rsv_ok    = rsv_en && (rsv_zero || !busy[rsv_addr] ||
                           (wr_en && (wr_addr == rsv_addr)));
    rsv_set   = rsv_ok && !rsv_zero;
    rel_hit   = wr_en && busy[wr_addr] && !wr_zero;
    busy_next = busy;
    if (wr_en) begin
      busy_next[wr_addr] = 1'b0;
    end
    if (rsv_set) begin
      busy_next[rsv_addr] = 1'b1;
    end
    cnt_next = busy_cnt + CNT_W'(rsv_set) - CNT_W'(rel_hit);
  end

  // A same-cycle release of the source register clears the stall.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a          = rd_addr[i*ADDR_W +: ADDR_W];
    assign rd_busy[i] = busy[a] && !(wr_en && (wr_addr == a));
  end

  always_ff @(posedge clk) begin
    if (startin) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// General-purpose register file with N combinational read ports, same-cycle
// write forwarding, optional hardwired-zero r0 and a busy scoreboard.
//   clk, startin      : clock, synchronous active-high reset
//   rd_addr / rd_data : packed read ports, port i at [i*W +: W]
//   rd_busy           : port i source register has an unreleased reservation
//   wr_en/addr/data   : writeback port, also releases the reservation
//   rsv_en/addr/ok    : reservation request and combinational accept
//   busy_cnt          : registers currently reserved
//   dbg_addr/dbg_data : architectural contents, no forwarding
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     startin,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_ok,
  output logic [ADDR_W:0]          busy_cnt,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int unsigned NREGS_L = 2 ** ADDR_W;
  localparam bit          ZR      = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs [NREGS_L];
  logic              wr_zero;

  assign wr_zero = ZR && (wr_addr == '0);

  // Storage: r0 writes are dropped when it is hardwired to zero.
  always_ff @(posedge clk) begin
    if (startin) begin
      for (int k = 0; k < int'(NREGS_L); k++) begin
        regs[k] <= '0;
      end
    end else if (wr_en && !wr_zero) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read ports with writeback forwarding; r0 is forced to zero explicitly so it
  // never depends on the array contents.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    assign a = rd_addr[i*ADDR_W +: ADDR_W];
    always_comb begin
      d = regs[a];
      if (ZR && (a == '0)) begin
        d = '0;
      end else if (wr_en && (wr_addr == a)) begin
        d = wr_data;
      end
    end
    assign rd_data[i*DATA_W +: DATA_W] = d;
  end

  // Debug view of the architectural state only.
  always_comb begin
    dbg_data = regs[dbg_addr];
    if (ZR && (dbg_addr == '0)) begin
      dbg_data = '0;
    end
  end

  reg_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk     (clk),
    .startin (startin),
    .rd_addr (rd_addr),
    .rd_busy (rd_busy),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .rsv_en  (rsv_en),
    .rsv_addr(rsv_addr),
    .rsv_ok  (rsv_ok),
    .busy_cnt(busy_cnt)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard with default parameters (32-bit, 32 regs, 2 ports, r0 zero).
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        startin;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        rsv_ok;
  logic [5:0]  busy_cnt;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk     (clk),
    .startin (startin),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_busy (rd_busy),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rsv_en  (rsv_en),
    .rsv_addr(rsv_addr),
    .rsv_ok  (rsv_ok),
    .busy_cnt(busy_cnt),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [4:0]  da;
    bit          chk;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [1:0]  e_busy;
    logic        e_ok;
    logic [5:0]  e_cnt;
    logic [31:0] e_dbg;
  } vec_t;

  vec_t exp_q [$];
  vec_t vt [21];

  function automatic vec_t mk(logic rst, logic we, logic [4:0] wa, logic [31:0] wd,
                              logic re, logic [4:0] ra, logic [4:0] a0, logic [4:0] a1,
                              logic [4:0] da, bit chk, logic [31:0] rd0, logic [31:0] rd1,
                              logic [1:0] bsy, logic ok, logic [5:0] cnt, logic [31:0] dbg);
    vec_t v;
    v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
    v.a0 = a0; v.a1 = a1; v.da = da; v.chk = chk;
    v.e_rd0 = rd0; v.e_rd1 = rd1; v.e_busy = bsy; v.e_ok = ok; v.e_cnt = cnt; v.e_dbg = dbg;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectations, then check mid-cycle.
  task automatic run_vec(input vec_t v, input string tag);
    vec_t e;
    @(posedge clk);
    #1;
    startin  = v.rst;
    wr_en    = v.we;
    wr_addr  = v.wa;
    wr_data  = v.wd;
    rsv_en   = v.re;
    rsv_addr = v.ra;
    rd_addr  = {v.a1, v.a0};
    dbg_addr = v.da;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    if (e.chk) begin
      cmp({tag, " rd_data0"}, rd_data[31:0], e.e_rd0);
      cmp({tag, " rd_data1"}, rd_data[63:32], e.e_rd1);
      cmp({tag, " rd_busy"}, 32'(rd_busy), 32'(e.e_busy));
      cmp({tag, " rsv_ok"}, 32'(rsv_ok), 32'(e.e_ok));
      cmp({tag, " busy_cnt"}, 32'(busy_cnt), 32'(e.e_cnt));
      cmp({tag, " dbg_data"}, dbg_data, e.e_dbg);
      checks++;
      if (busy_cnt > 6'd31) begin
        errors++;
        $display("FAIL %s busy_cnt range: got %0d limit 31", tag, busy_cnt);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    startin = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; rd_addr = '0; dbg_addr = '0;

    //          rst we wa  wd            re ra a0 a1 da chk rd0           rd1           busy   ok cnt dbg
    vt[0]  = mk(1, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        2'b00, 0, 0, 32'h0);
    vt[1]  = mk(0, 1, 3, 32'hDEADBEEF, 0, 0, 3, 3, 3, 1, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0, 0, 32'h0);
    vt[2]  = mk(0, 0, 0, 32'h0,        0, 0, 3, 0, 3, 1, 32'hDEADBEEF, 32'h0,        2'b00, 0, 0, 32'hDEADBEEF);
    vt[3]  = mk(1, 0, 0, 32'h0,        0, 0, 3, 0, 0, 0, 32'h0,        32'h0,        2'b00, 0, 0, 32'h0);
    vt[4]  = mk(0, 0, 0, 32'h0,        0, 0, 3, 3, 3, 1, 32'h0,        32'h0,        2'b00, 0, 0, 32'h0);
    vt[5]  = mk(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        2'b00, 0, 0, 32'h0);
    vt[6]  = mk(0, 0, 0, 32'h0,        1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        2'b00, 1, 0, 32'h0);
    vt[7]  = mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        2'b00, 0, 0, 32'h0);
    vt[8]  = mk(0, 0, 0, 32'h0,        1, 5, 5, 0, 0, 1, 32'h0,        32'h0,        2'b00, 1, 0, 32'h0);
    vt[9]  = mk(0, 0, 0, 32'h0,        1, 5, 5, 5, 0, 1, 32'h0,        32'h0,        2'b11, 0, 1, 32'h0);
    vt[10] = mk(0, 1, 5, 32'h12345678, 0, 0, 5, 5, 5, 1, 32'h12345678, 32'h12345678, 2'b00, 0, 1, 32'h0);
    vt[11] = mk(0, 0, 0, 32'h0,        0, 0, 5, 0, 5, 1, 32'h12345678, 32'h0,        2'b00, 0, 0, 32'h12345678);
    vt[12] = mk(0, 0, 0, 32'h0,        1, 7, 7, 0, 0, 1, 32'h0,        32'h0,        2'b00, 1, 0, 32'h0);
    vt[13] = mk(0, 1, 7, 32'hAA,       1, 7, 7, 7, 7, 1, 32'hAA,       32'hAA,       2'b00, 1, 1, 32'h0);
    vt[14] = mk(0, 0, 0, 32'h0,        0, 0, 7, 7, 7, 1, 32'hAA,       32'hAA,       2'b11, 0, 1, 32'hAA);
    vt[15] = mk(0, 0, 0, 32'h0,        1, 1, 1, 0, 0, 1, 32'h0,        32'h0,        2'b00, 1, 1, 32'h0);
    vt[16] = mk(0, 0, 0, 32'h0,        1, 2, 1, 2, 0, 1, 32'h0,        32'h0,        2'b01, 1, 2, 32'h0);
    vt[17] = mk(0, 0, 0, 32'h0,        1, 3, 2, 3, 0, 1, 32'h0,        32'h0,        2'b01, 1, 3, 32'h0);
    vt[18] = mk(0, 0, 0, 32'h0,        0, 0, 3, 7, 0, 1, 32'h0,        32'hAA,       2'b11, 0, 4, 32'h0);
    vt[19] = mk(1, 1, 1, 32'h55,       1, 4, 0, 0, 0, 0, 32'h0,        32'h0,        2'b00, 0, 0, 32'h0);
    vt[20] = mk(0, 0, 0, 32'h0,        0, 0, 1, 7, 1, 1, 32'h0,        32'h0,        2'b00, 0, 0, 32'h0);

    for (int i = 0; i < 21; i++) begin
      run_vec(vt[i], $sformatf("vec%0d", i));
    end

    // Fill the scoreboard with every nonzero register.
    for (int i = 1; i < 32; i++) begin
      run_vec(mk(0, 0, 0, 32'h0, 1, 5'(i), 5'(i), 5'(i - 1), 0, 1, 32'h0, 32'h0,
                 {(i > 1), 1'b0}, 1, 6'(i - 1), 32'h0), $sformatf("fill%0d", i));
    end
    run_vec(mk(0, 0, 0, 32'h0, 1, 9, 9, 0, 0, 1, 32'h0, 32'h0, 2'b01, 0, 31, 32'h0), "full_waw");
    run_vec(mk(0, 0, 0, 32'h0, 1, 0, 0, 31, 0, 1, 32'h0, 32'h0, 2'b10, 1, 31, 32'h0), "full_r0");

    // Drain by writing every register back.
    for (int i = 1; i < 32; i++) begin
      run_vec(mk(0, 1, 5'(i), 32'(i), 0, 0, 5'(i), 31, 5'(i), 1, 32'(i),
                 (i == 31) ? 32'd31 : 32'h0, {(i < 31), 1'b0}, 0, 6'(32 - i), 32'h0),
              $sformatf("drain%0d", i));
    end
    run_vec(mk(0, 0, 0, 32'h0, 0, 0, 31, 30, 31, 1, 32'd31, 32'd30, 2'b00, 0, 0, 32'd31), "drained");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
